inst_fetch: RTL

Instruction fetch stage for the 8-bit CPU. It owns the program counter and reads 8-bit instructions from instruction memory over a request/acknowledge port. Fetched instructions are buffered in a small FIFO and presented to the CPU's `inst` input with a valid/ready handshake. A redirect input flushes in-flight work and restarts fetch at a new address. This replaces the bench-driven `inst` used today.

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/inst_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Also provides the saturating increment used by the optional stall counter.
package inst_fetch_pkg;

    localparam int unsigned INST_W  = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWait    = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + STALL_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of WIDTH bits, wrap-bit pointers, flush beats push/pop.
// The head reads as zero whenever the FIFO is empty.
module fetch_fifo #(
    parameter int unsigned  DEPTH = 4,
    parameter int unsigned  WIDTH = 16,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned PTR_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [PTR_W-1:0] count,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        wr_idx  = wr_ptr_q[IDX_W-1:0];
        rd_idx  = rd_ptr_q[IDX_W-1:0];
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        do_pop  = pop && !empty;
        // A pop frees the slot being written, so push on full is fine alongside it.
        do_push = push && (!full || do_pop);
        count   = wr_ptr_q - rd_ptr_q;
        head    = empty ? '0 : mem_q[rd_idx];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, one outstanding memory read, prefetch FIFO to the CPU.
// Define INST_FETCH_PERF_EN to add the stall_cycles starvation counter port.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [INST_W-1:0]   mem_rdata,
    output logic [INST_W-1:0]   inst,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [STALL_W-1:0]  stall_cycles
`endif
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = INST_W + ADDR_W;

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    count_next;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                req_free;
    logic                issue;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({mem_rdata, mem_addr}),
        .count (fifo_count),
        .head  (fifo_head),
        .empty (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_head[ENTRY_W-1:ADDR_W];
    assign inst_pc    = fifo_head[ADDR_W-1:0];
    assign mem_req    = (state_q != StIdle);
    assign mem_addr   = addr_q;

    always_comb begin
        // A redirect flushes the FIFO, so any pop or push in that cycle is void.
        pop  = inst_valid && inst_ready && !redirect;
        push = (state_q == StWait) && mem_ack && !redirect;

        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        count_next = redirect ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
        issue      = (count_next < CNT_W'(DEPTH));

        state_d  = state_q;
        addr_d   = addr_q;
        req_free = 1'b0;
        unique case (state_q)
            StIdle: req_free = 1'b1;
            StWait: begin
                if (mem_ack) begin
                    req_free = 1'b1;
                end else if (redirect) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: req_free = mem_ack;
            default: begin
                state_d = StIdle;
            end
        endcase

        if (req_free) begin
            if (issue) begin
                state_d = StWait;
                addr_d  = pc_d;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

`ifdef INST_FETCH_PERF_EN
    logic [STALL_W-1:0] stall_q;

    // Counts cycles where the CPU wanted an instruction and none was ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (inst_ready && !inst_valid) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
